// File: rtl/conv_mac_stage.sv
// ============================================================================
//  Module   : conv_mac_stage
//  Purpose  : Pops FIFO samples into a KTAPS-deep sliding window and emits one
//             signed dot product per new sample, one multiply per cycle, on a
//             valid/ready port. Optional macro CONV_MAC_SAT_EN clamps results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_mac_stage #(
    parameter int FIFO_W = 32,
    parameter int DATA_W = 16,
    parameter int KTAPS  = 3,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [FIFO_W-1:0]          fifo_data,
    input  logic                       coef_wr,
    input  logic [$clog2(KTAPS)-1:0]   coef_addr,
    input  logic [DATA_W-1:0]          coef_data,
    output logic                       coef_busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data
);

    localparam int TAP_W  = $clog2(KTAPS);
    localparam int FILL_W = $clog2(KTAPS + 1);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [TAP_W-1:0]  c_last_tap  = TAP_W'(KTAPS - 1);
    localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(KTAPS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_win  [KTAPS];
    logic signed [DATA_W-1:0]  r_coef [KTAPS];
    logic [FILL_W-1:0]         r_fill;
    logic signed [ACC_W-1:0]   r_acc;
    logic [TAP_W-1:0]          r_tap;
    logic                      r_out_valid;
    logic [OUT_W-1:0]          r_out_data;

    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic [FILL_W-1:0]         w_fill_next;
    logic [OUT_W-1:0]          w_out;
    logic                      w_unused_fifo_hi;

    assign fifo_rd_en = (r_state == S_IDLE) && !fifo_empty && !rst;
    assign coef_busy  = (r_state != S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

    // Only the low DATA_W bits of a FIFO word carry the sample.
    assign w_unused_fifo_hi = ^fifo_data[FIFO_W-1:DATA_W];

    assign w_prod      = r_win[r_tap] * r_coef[r_tap];
    assign w_acc_next  = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_fill_next = (r_fill == c_fill_full) ? r_fill : r_fill + FILL_W'(1);

`ifdef CONV_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] c_out_max =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_out_min =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        w_out = w_acc_next[OUT_W-1:0];
        if (w_acc_next > c_out_max) begin
            w_out = c_out_max[OUT_W-1:0];
        end else if (w_acc_next < c_out_min) begin
            w_out = c_out_min[OUT_W-1:0];
        end
    end
`else
    assign w_out = w_acc_next[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fill      <= '0;
            r_acc       <= '0;
            r_tap       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < KTAPS; i++) begin
                r_win[i]  <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && coef_wr && (int'(coef_addr) < KTAPS)) begin
                r_coef[coef_addr] <= coef_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_win[0] <= fifo_data[DATA_W-1:0];
                    for (int i = 1; i < KTAPS; i++) begin
                        r_win[i] <= r_win[i-1];
                    end
                    r_fill <= w_fill_next;
                    // Until the window is full, samples only prime it.
                    if (w_fill_next == c_fill_full) begin
                        r_acc   <= '0;
                        r_tap   <= '0;
                        r_state <= S_COMPUTE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    if (r_tap == c_last_tap) begin
                        r_tap       <= '0;
                        r_out_data  <= w_out;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else begin
                        r_tap <= r_tap + TAP_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_stage.sv
// ============================================================================
//  Module   : tb_conv_mac_stage
//  Purpose  : Scoreboard bench for conv_mac_stage with a queue-backed FIFO
//             model and a reference dot-product model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_mac_stage;

    localparam int KT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic        coef_wr;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data;
    logic        coef_busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_cyc = 0;

    logic [15:0] fq[$];
    logic [31:0] exp_q[$];
    longint      m_win  [KT];
    longint      m_coef [KT];
    int          m_fill;

    always #5 clk = ~clk;

    conv_mac_stage dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .coef_wr    (coef_wr),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_busy  (coef_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    // FIFO model: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            fifo_data  <= {16'hA5C3, fq.pop_front()};
            fifo_empty <= (fq.size() == 0);
            rd_cyc     <= cyc;
        end
    end

    function automatic logic [31:0] conv(input longint s);
        logic [31:0] r;
        r = s[31:0];
`ifdef CONV_MAC_SAT_EN
        if (s > 64'sd2147483647)  r = 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) r = 32'h8000_0000;
`endif
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_fill = 0;
        for (int i = 0; i < KT; i++) begin
            m_win[i]  = 0;
            m_coef[i] = 0;
        end
    endtask

    task automatic push_sample(input int v);
        longint s;
        fq.push_back(v[15:0]);
        fifo_empty = 1'b0;
        for (int i = KT - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = longint'($signed(v[15:0]));
        if (m_fill < KT) m_fill++;
        if (m_fill == KT) begin
            s = 0;
            for (int i = 0; i < KT; i++) s += m_win[i] * m_coef[i];
            exp_q.push_back(conv(s));
        end
    endtask

    task automatic push_settle(input int v);
        push_sample(v);
        repeat (4) @(negedge clk);
    endtask

    task automatic write_coef(input int a, input int v);
        coef_wr   = 1'b1;
        coef_addr = a[1:0];
        coef_data = v[15:0];
        @(negedge clk);
        coef_wr = 1'b0;
        if (a < KT) m_coef[a] = longint'($signed(v[15:0]));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        out_ready  = 1'b0;
        coef_wr    = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s: out_valid high in %0d cycles, required 0", name, seen);
        end
    endtask

    task automatic wait_result(input string name, input bit check_lat);
        int n = 0;
        logic [31:0] e;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s: timeout, out_valid=%b required 1", name, out_valid);
            return;
        end
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected result %h, required none", name, out_data);
        end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
                bad++;
                $display("FAIL %s: out_data=%h required %h", name, out_data, e);
            end
        end
        if (check_lat) begin
            total++;
            if (cyc - rd_cyc != KT + 2) begin
                bad++;
                $display("FAIL %s_latency: got %0d required %0d", name, cyc - rd_cyc, KT + 2);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_accept: out_valid=%b required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0) begin
                bad++;
                $display("FAIL reset_idle: rd_en=%b valid=%b data=%h required 0 0 0",
                         fifo_rd_en, out_valid, out_data);
            end
        end
    endtask

    task automatic test_basic();
        write_coef(0, 1);
        write_coef(1, 2);
        write_coef(2, 3);
        push_settle(1);
        push_settle(2);
        expect_quiet("priming", 10);
        push_sample(3);
        wait_result("basic_10", 1'b1);
        push_sample(4);
        wait_result("basic_16", 1'b1);
    endtask

    task automatic test_backpressure();
        int n = 0;
        push_sample(5);
        push_sample(6);
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || fifo_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL hold: valid=%b data=%h rd_en=%b required 1 %h 0",
                         out_valid, out_data, fifo_rd_en, exp_q[0]);
            end
        end
        wait_result("bp_22", 1'b0);
        wait_result("bp_28", 1'b1);
        total++;
        if (fq.size() != 0) begin
            bad++;
            $display("FAIL bp_pop: fifo depth=%0d required 0", fq.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < KT; i++) write_coef(i, 32767);
        push_settle(32767);
        push_settle(32767);
        push_sample(32767);
        wait_result("overflow", 1'b0);
    endtask

    task automatic test_coef_busy();
        do_reset();
        write_coef(0, 1);
        write_coef(1, 2);
        write_coef(2, 3);
        push_settle(1);
        push_settle(2);
        push_sample(3);
        @(negedge clk);
        @(negedge clk);
        coef_wr   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 16'd9;
        total++;
        if (coef_busy !== 1'b1) begin
            bad++;
            $display("FAIL coef_busy: got %b required 1", coef_busy);
        end
        @(negedge clk);
        coef_wr = 1'b0;
        wait_result("busy_10", 1'b0);
        push_sample(4);
        wait_result("busy_16", 1'b0);
    endtask

    task automatic test_reset_midop();
        push_sample(5);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        fifo_empty = 1'b0;
        @(negedge clk);
        total++;
        if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || coef_busy !== 1'b0 ||
            out_data !== 32'd0) begin
            bad++;
            $display("FAIL midop_rst: rd_en=%b valid=%b busy=%b data=%h required 0 0 0 0",
                     fifo_rd_en, out_valid, coef_busy, out_data);
        end
        rst        = 1'b0;
        fifo_empty = 1'b1;
        fq.delete();
        model_clear();
        push_settle(7);
        push_settle(8);
        expect_quiet("rst_priming", 10);
        push_sample(9);
        wait_result("rst_coef0", 1'b0);
        write_coef(0, 1);
        write_coef(1, 2);
        write_coef(2, 3);
        push_sample(10);
        wait_result("rst_52", 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        coef_wr    = 1'b0;
        coef_addr  = '0;
        coef_data  = '0;
        out_ready  = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_coef_busy();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
